// File: rtl/vedic_pp_combiner_pkg.sv
// Shared widths for the Vedic partial-product combiner.
// Sub-products are 2N bits, the middle sum keeps its carry at 2N+1 bits,
// the recombined product is 4N bits, and the optional stats counter is 16 bits.
package vedic_pp_combiner_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int TAG_W_DEFAULT = 4;
  localparam int STATS_W       = 16;

  function automatic int pp_width(input int n);
    return 2 * n;
  endfunction

  function automatic int mid_width(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int prod_width(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/vedic_pp_combiner_if.sv
// Valid/ready bus between the lower Vedic level, the combiner and its consumer.
// The master side drives sub-products and out_ready; the slave is the combiner.
interface vedic_pp_combiner_if
  import vedic_pp_combiner_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
);

  logic                     in_valid;
  logic                     in_ready;
  logic [pp_width(N)-1:0]   pp_ll;
  logic [pp_width(N)-1:0]   pp_lh;
  logic [pp_width(N)-1:0]   pp_hl;
  logic [pp_width(N)-1:0]   pp_hh;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [prod_width(N)-1:0] product;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output in_valid, pp_ll, pp_lh, pp_hl, pp_hh, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag
  );

  modport slave (
    input  in_valid, pp_ll, pp_lh, pp_hl, pp_hh, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag
  );

endinterface

// File: rtl/vedic_pp_combiner_pipe_stage.sv
// vedic_pipe_stage: generic valid/ready register slice.
// It loads whenever it is empty or its content is leaving, so a full slice
// can be refilled in the same cycle it is drained (no bubble).
module vedic_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic adv;

  // The slice can take new data when empty or when its current word is accepted.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // Register the word on advance; data is only overwritten by a real transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/vedic_pp_combiner.sv
// vedic_pp_combiner: final recombination stage of a 2N x 2N Vedic multiplier.
// S1 registers mid = pp_lh + pp_hl (with carry) and cat = {pp_hh, pp_ll};
// S2 registers product = cat + (mid << N). Up to two sets are buffered.
// Optional build macro VEDIC_COMB_STATS_EN adds a 16-bit txn_count output
// counting accepted products.
module vedic_pp_combiner
  import vedic_pp_combiner_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  vedic_pp_combiner_if.slave   bus
`ifdef VEDIC_COMB_STATS_EN
  ,
  output logic [STATS_W-1:0]   txn_count
`endif
);

  localparam int MID_W  = mid_width(N);
  localparam int PROD_W = prod_width(N);
  localparam int S1_W   = MID_W + PROD_W + TAG_W;
  localparam int S2_W   = PROD_W + TAG_W;

  logic [MID_W-1:0]  mid_in;
  logic [PROD_W-1:0] cat_in;
  logic [S1_W-1:0]   s1_in_data;
  logic [S1_W-1:0]   s1_data;
  logic              s1_valid;
  logic              s1_in_ready;
  logic              s2_in_ready;
  logic [MID_W-1:0]  s1_mid;
  logic [PROD_W-1:0] s1_cat;
  logic [TAG_W-1:0]  s1_tag;
  logic [PROD_W-1:0] s2_sum;
  logic [S2_W-1:0]   s2_in_data;
  logic [S2_W-1:0]   s2_data;

  // Stage-1 operands: carry-preserving middle sum and the concatenated outer terms.
  always_comb begin
    mid_in     = {1'b0, bus.pp_lh} + {1'b0, bus.pp_hl};
    cat_in     = {bus.pp_hh, bus.pp_ll};
    s1_in_data = {mid_in, cat_in, bus.in_tag};
  end

  vedic_pipe_stage #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in_data),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_data)
  );

  // Stage-2 operand: fold the shifted middle sum into the outer terms, modulo 2^4N.
  always_comb begin
    s1_mid     = s1_data[S1_W-1 -: MID_W];
    s1_cat     = s1_data[TAG_W +: PROD_W];
    s1_tag     = s1_data[TAG_W-1:0];
    s2_sum     = s1_cat + (PROD_W'(s1_mid) << N);
    s2_in_data = {s2_sum, s1_tag};
  end

  vedic_pipe_stage #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (s2_data)
  );

  // Expose the output register and the upstream ready.
  always_comb begin
    bus.in_ready = s1_in_ready;
    bus.product  = s2_data[S2_W-1:TAG_W];
    bus.out_tag  = s2_data[TAG_W-1:0];
  end

`ifdef VEDIC_COMB_STATS_EN
  // Count accepted products; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      txn_count <= txn_count + 1'b1;
    end
  end
`else
  // Statistics disabled: no counter and no extra port.
`endif

endmodule
